m_int_accept_unit: RTL
======================

// Module: m_int_accept_unit
// PURPOSE
// - Hart-side consumer of the external interrupt controller's mextern_int/mextern_int_id, plus timer and software lines.
// - Holds the machine interrupt CSRs (mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause).
// - Arbitrates pending interrupts and raises a trap request to the core pipeline.
// - Core accepts the request at an instruction boundary via int_ack; the block saves state and supplies trap_pc.
// PARAMETERS
// - MTVEC_RST  32'h0000_0000  reset value of mtvec (base, mode 0)
// PORTS
// - hb_clk          in   1   system clock
// - rst_sync        in   1   synchronous active-high reset
// - mextern_int     in   1   external interrupt pending (registered by controller)
// - mextern_int_id  in   31  external cause code (platform codes >=16)
// - mtimer_int      in   1   machine timer interrupt level
// - msoft_int       in   1   machine software interrupt level
// - csr_we          in   1   CSR write strobe from core
// - csr_addr        in   12  CSR address (read and write)
// - csr_wdata       in   32  CSR write data (already ALU-resolved: csrrw/rs/rc)
// - csr_rdata       out  32  CSR read data, combinational on csr_addr
// - csr_hit         out  1   csr_addr is one of the CSRs below
// - int_req         out  1   trap request to core
// - int_ack         in   1   core takes trap this cycle; valid only while int_req=1
// - ack_pc          in   32  PC of the interrupted instruction, sampled on int_ack
// - mret            in   1   core retires mret this cycle
// - trap_pc         out  32  trap target, valid while int_req=1
// - mepc_o          out  32  current mepc, for mret redirect
// BEHAVIOUR
// - Clock hb_clk; reset rst_sync is synchronous, active-high.
// - Reset: MIE=0, MPIE=0, mie=0, mtvec=MTVEC_RST, mepc=0, mcause=0, state=IDLE, int_req=0, cause_q=0.
// - CSRs:
//   - 0x300 mstatus: bit3 MIE, bit7 MPIE, bits[12:11] MPP read 2'b11; other bits read 0 and ignore writes.
//   - 0x304 mie: bits 3/7/11 (MSIE/MTIE/MEIE) writable; others read 0.
//   - 0x305 mtvec: writable; mode handling per CONFIGURATION.
//   - 0x341 mepc: bits[1:0] forced 0.
//   - 0x342 mcause: fully writable.
//   - 0x344 mip: read-only {MEIP=mextern_int @11, MTIP @7, MSIP @3}; writes ignored.
//   - Unlisted addresses: csr_hit=0, csr_rdata=0.
// - Eligible set: E = mip & mie, gated by MIE.
// - Priority: MEI > MSI > MTI.
// - Cause = {1'b1, mextern_int_id} for MEI; {1'b1, 31'd3} for MSI; {1'b1, 31'd7} for MTI.
// - FSM:
//   - IDLE -> PEND when E!=0 and MIE=1. int_req rises the cycle after the source is seen (1-cycle latency). cause_q is registered.
//   - PEND: cause_q re-arbitrated every cycle. If E==0 or MIE==0, return to IDLE and drop int_req next cycle (withdrawal).
//   - PEND & int_ack -> IDLE. Same edge: mepc<=ack_pc&~3, mcause<=cause_q, MPIE<=MIE, MIE<=0.
// - int_ack while int_req=0: ignored.
// - mret: MIE<=MPIE, MPIE<=1.
// - Simultaneous events:
//   - int_ack beats withdrawal: trap taken with current cause_q.
//   - int_ack beats mret (mret ignored).
//   - Trap update beats a same-cycle csr_we to mstatus/mepc/mcause. csr_we to other CSRs still applies.
// - csr_we to mstatus clearing MIE in PEND: withdrawal next cycle. int_ack on that same edge still wins.
// - mextern_int_id changing while in PEND: cause_q follows it. Value at the int_ack edge is saved.
// - Reset mid-PEND: int_req drops on the next edge; no CSR state is saved.
// CONFIGURATION
// - Macro M_INT_VECTORED_EN.
// - Defined:
//   - mtvec[1:0] writable, values 0/1 only; writes of 2/3 store 0.
//   - Mode 1: trap_pc = {mtvec[31:2],2'b00} + (cause_q[30:0]<<2), 32-bit wrap.
//   - Mode 0: trap_pc = base.
// - Undefined: mtvec[1:0] hardwired 0; trap_pc = base always.
// TESTING
// - MEIE=1, MIE=1, mextern_int=1, id=18 -> int_req at +1 cycle. On ack with ack_pc=0x100: mepc=0x100, mcause=0x8000_0012, MIE=0, MPIE=1.
// - MEI, MSI, MTI all pending and enabled -> mcause=0x8000_000B-class MEI (id value). Drop MEI in PEND -> cause_q becomes 0x8000_0003.
// - PEND, then mextern_int falls with no ack -> int_req=0 next cycle, state IDLE, mepc unchanged.
// - After trap, mret -> MIE=1, MPIE=1. mret with int_ack in the same cycle -> trap wins, MIE=0.
// - csr_we mstatus=0 on the same edge as int_ack -> MPIE=1 (old MIE), MIE=0. Write mip=0xFFFF -> mip unchanged.
// - With M_INT_VECTORED_EN: mtvec=0x1001, MTI -> trap_pc=0x101C. Without it: mtvec reads 0x1000 and trap_pc=0x1000.

Source files
------------

// File: rtl/m_int_accept_unit.sv
// m_int_accept_unit: machine interrupt CSRs, source arbitration and trap handshake with the core.
// Define M_INT_VECTORED_EN to enable mtvec vectored mode (mode 1).
module m_int_accept_unit #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        hb_clk,
    input  logic        rst_sync,
    input  logic        mextern_int,
    input  logic [30:0] mextern_int_id,
    input  logic        mtimer_int,
    input  logic        msoft_int,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_hit,
    output logic        int_req,
    input  logic        int_ack,
    input  logic [31:0] ack_pc,
    input  logic        mret,
    output logic [31:0] trap_pc,
    output logic [31:0] mepc_o
);
    typedef enum logic {IDLE, PEND} state_t;
    state_t      state_q;
    logic        mie_q, mpie_q;
    logic [11:0] mien_q;
    logic [31:0] mtvec_q, mepc_q, mcause_q, cause_q;
    logic [11:0] mip, elig;
    logic        pend, take;
    logic [31:0] arb_cause, mtvec_d;

    assign mip       = {mextern_int, 3'b000, mtimer_int, 3'b000, msoft_int, 3'b000};
    assign elig      = mip & mien_q;
    assign pend      = mie_q && (elig != 12'd0);
    assign take      = int_ack && (state_q == PEND);
    assign arb_cause = elig[11] ? {1'b1, mextern_int_id} : elig[3] ? 32'h8000_0003 : 32'h8000_0007;
    assign int_req   = (state_q == PEND);
    assign mepc_o    = mepc_q;

`ifdef M_INT_VECTORED_EN
    localparam logic [31:0] MTVEC_INIT = MTVEC_RST;
    assign mtvec_d = {csr_wdata[31:2], 1'b0, csr_wdata[1:0] == 2'b01};
    assign trap_pc = (mtvec_q[1:0] == 2'b01) ? {mtvec_q[31:2], 2'b00} + {cause_q[29:0], 2'b00}
                                              : {mtvec_q[31:2], 2'b00};
`else
    localparam logic [31:0] MTVEC_INIT = MTVEC_RST & 32'hFFFF_FFFC;
    assign mtvec_d = {csr_wdata[31:2], 2'b00};
    assign trap_pc = mtvec_q;
`endif

    always_ff @(posedge hb_clk) begin
        if (rst_sync) begin
            state_q  <= IDLE;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mien_q   <= 12'd0;
            mtvec_q  <= MTVEC_INIT;
            mepc_q   <= 32'd0;
            mcause_q <= 32'd0;
            cause_q  <= 32'd0;
        end else begin
            if (csr_we && csr_addr == 12'h304) mien_q <= csr_wdata[11:0] & 12'h888;
            if (csr_we && csr_addr == 12'h305) mtvec_q <= mtvec_d;
            // Trap entry overrides mret and any same-cycle write to mstatus/mepc/mcause
            if (take) begin
                mepc_q   <= ack_pc & 32'hFFFF_FFFC;
                mcause_q <= cause_q;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else begin
                if (csr_we && csr_addr == 12'h341) mepc_q <= csr_wdata & 32'hFFFF_FFFC;
                if (csr_we && csr_addr == 12'h342) mcause_q <= csr_wdata;
                if (mret) begin
                    mie_q  <= mpie_q;
                    mpie_q <= 1'b1;
                end else if (csr_we && csr_addr == 12'h300) begin
                    mie_q  <= csr_wdata[3];
                    mpie_q <= csr_wdata[7];
                end
            end
            case (state_q)
                IDLE: if (pend) begin
                    state_q <= PEND;
                    cause_q <= arb_cause;
                end
                PEND: if (take || !pend) state_q <= IDLE;
                      else cause_q <= arb_cause;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        csr_rdata = 32'd0;
        csr_hit   = 1'b1;
        case (csr_addr)
            12'h300: csr_rdata = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
            12'h304: csr_rdata = {20'd0, mien_q};
            12'h305: csr_rdata = mtvec_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h344: csr_rdata = {20'd0, mip};
            default: csr_hit = 1'b0;
        endcase
    end
endmodule
